// File: rtl/cmdseq_if.sv
// Host, CMD transmitter and data-path handshake bundle for cmdseq.
// slave is the sequencer side; master is the environment driving it.
interface cmdseq_if;
  logic        init_done;
  logic [15:0] rca;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] blk_addr;
  logic [15:0] blk_cnt;
  logic        ready;
  logic        done;
  logic        err;
  logic        cmd7st;
  logic        cmd12st;
  logic        cmd13st;
  logic        cmd17st;
  logic        cmd18st;
  logic        cmd23st;
  logic        cmd24st;
  logic [31:0] cmd_arg;
  logic        cmd_start;
  logic        cmd_done;
  logic        resp_err;
  logic        resp_ready;
  logic        data_done;
  logic        data_err;

  modport slave (
    input  init_done, rca, rd_req, wr_req, blk_addr, blk_cnt,
    input  cmd_done, resp_err, resp_ready, data_done, data_err,
    output ready, done, err, cmd_arg, cmd_start,
    output cmd7st, cmd12st, cmd13st, cmd17st, cmd18st, cmd23st, cmd24st
  );

  modport master (
    output init_done, rca, rd_req, wr_req, blk_addr, blk_cnt,
    output cmd_done, resp_err, resp_ready, data_done, data_err,
    input  ready, done, err, cmd_arg, cmd_start,
    input  cmd7st, cmd12st, cmd13st, cmd17st, cmd18st, cmd23st, cmd24st
  );
endinterface

// File: rtl/cmdseq.sv
// SD card command sequencer: issues CMD7/13/23/17/18/24/12 for one block
// read or write request and handshakes with the CMD transmitter and data path.
module cmdseq #(
  parameter int unsigned STAT_RETRY = 255
) (
  input logic      clk,
  input logic      reset,
  cmdseq_if.slave  io_bus
);

  typedef enum logic [2:0] {
    StIdle, StSel, StStat, StSbc, StXfer, StDwait, StStop, StErr
  } state_e;

  localparam logic [8:0] RetryMax = 9'(STAT_RETRY);

  state_e      r_state, w_state_d;
  logic        r_selected, w_selected_d;
  logic [31:0] r_addr, w_addr_d;
  logic [15:0] r_remain, w_remain_d;
  logic        r_dir, w_dir_d;  // 1 = write
  logic [7:0]  r_retry, w_retry_d;
  logic        r_err, w_err_d;
  logic        r_done, w_done_d;
  logic        r_cmd_start, w_cmd_start_d;

  logic        w_multi;
  logic [8:0]  w_retry_inc;
  logic [6:0]  w_strobes;
  logic [31:0] w_arg;

  assign w_multi     = !r_dir && (r_remain > 16'd1);
  assign w_retry_inc = {1'b0, r_retry} + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_selected  <= 1'b0;
      r_addr      <= 32'h0;
      r_remain    <= 16'h0;
      r_dir       <= 1'b0;
      r_retry     <= 8'h0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_start <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_selected  <= w_selected_d;
      r_addr      <= w_addr_d;
      r_remain    <= w_remain_d;
      r_dir       <= w_dir_d;
      r_retry     <= w_retry_d;
      r_err       <= w_err_d;
      r_done      <= w_done_d;
      r_cmd_start <= w_cmd_start_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_selected_d  = r_selected;
    w_addr_d      = r_addr;
    w_remain_d    = r_remain;
    w_dir_d       = r_dir;
    w_retry_d     = r_retry;
    w_err_d       = r_err;
    w_done_d      = 1'b0;
    w_cmd_start_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (io_bus.init_done && (io_bus.rd_req || io_bus.wr_req)) begin
          w_addr_d      = io_bus.blk_addr;
          w_remain_d    = (io_bus.blk_cnt == 16'd0) ? 16'd1 : io_bus.blk_cnt;
          w_dir_d       = !io_bus.rd_req;
          w_err_d       = 1'b0;
          w_retry_d     = 8'h0;
          w_state_d     = r_selected ? StStat : StSel;
          w_cmd_start_d = 1'b1;
        end
      end
      StSel: begin
        if (io_bus.cmd_done) begin
          if (io_bus.resp_err) begin
            w_state_d = StErr;
          end else begin
            w_selected_d  = 1'b1;
            w_retry_d     = 8'h0;
            w_state_d     = StStat;
            w_cmd_start_d = 1'b1;
          end
        end
      end
      StStat: begin
        if (io_bus.cmd_done) begin
          if (io_bus.resp_err) begin
            w_state_d = StErr;
          end else if (io_bus.resp_ready) begin
            w_state_d     = w_multi ? StSbc : StXfer;
            w_cmd_start_d = 1'b1;
          end else if (w_retry_inc >= RetryMax) begin
            w_state_d = StErr;
          end else begin
            w_retry_d     = w_retry_inc[7:0];
            w_cmd_start_d = 1'b1;
          end
        end
      end
      StSbc: begin
        if (io_bus.cmd_done) begin
          if (io_bus.resp_err) begin
            w_state_d = StErr;
          end else begin
            w_state_d     = StXfer;
            w_cmd_start_d = 1'b1;
          end
        end
      end
      StXfer: begin
        if (io_bus.cmd_done) begin
          w_state_d = io_bus.resp_err ? StErr : StDwait;
        end
      end
      StDwait: begin
        if (io_bus.data_done) begin
          if (io_bus.data_err) begin
            // A failed multi-block read leaves the card in data state; stop it first.
            if (w_multi) begin
              w_state_d     = StStop;
              w_cmd_start_d = 1'b1;
            end else begin
              w_state_d = StErr;
            end
          end else if (!r_dir) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_addr_d   = r_addr + 32'd1;
            w_remain_d = r_remain - 16'd1;
            if (r_remain == 16'd1) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end else begin
              w_retry_d     = 8'h0;
              w_state_d     = StStat;
              w_cmd_start_d = 1'b1;
            end
          end
        end
      end
      StStop: begin
        if (io_bus.cmd_done) w_state_d = StErr;
      end
      StErr: begin
        w_selected_d = 1'b0;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StErr) w_err_d = 1'b1;

    // Card went away mid-sequence: drop everything and force reselect.
    if ((r_state != StIdle) && !io_bus.init_done) begin
      w_state_d     = StIdle;
      w_err_d       = 1'b1;
      w_selected_d  = 1'b0;
      w_done_d      = 1'b0;
      w_cmd_start_d = 1'b0;
    end
  end

  always_comb begin
    w_strobes = 7'b0;
    w_arg     = 32'h0;
    unique case (r_state)
      StSel: begin
        w_strobes[6] = 1'b1;
        w_arg        = {io_bus.rca, 16'h0000};
      end
      StStat: begin
        w_strobes[4] = 1'b1;
        w_arg        = {io_bus.rca, 16'h0000};
      end
      StSbc: begin
        w_strobes[1] = 1'b1;
        w_arg        = {16'h0000, r_remain};
      end
      StXfer: begin
        if (r_dir)        w_strobes[0] = 1'b1;
        else if (w_multi) w_strobes[2] = 1'b1;
        else              w_strobes[3] = 1'b1;
        w_arg = r_addr;
      end
      StStop: w_strobes[5] = 1'b1;
      default: ;
    endcase
  end

  assign io_bus.cmd7st    = w_strobes[6];
  assign io_bus.cmd12st   = w_strobes[5];
  assign io_bus.cmd13st   = w_strobes[4];
  assign io_bus.cmd17st   = w_strobes[3];
  assign io_bus.cmd18st   = w_strobes[2];
  assign io_bus.cmd23st   = w_strobes[1];
  assign io_bus.cmd24st   = w_strobes[0];
  assign io_bus.cmd_arg   = w_arg;
  assign io_bus.cmd_start = r_cmd_start;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;
  assign io_bus.ready     = (r_state == StIdle) && io_bus.init_done;

endmodule

// File: tb/tb_cmdseq.sv
// Self-checking bench for cmdseq: scoreboard of expected commands per request,
// with a responder that plays the CMD transmitter and data path.
module tb_cmdseq;

  typedef struct {
    logic [6:0]  st;
    logic [31:0] arg;
  } cmd_t;

  // Strobe vector order: {cmd7, cmd12, cmd13, cmd17, cmd18, cmd23, cmd24}
  localparam logic [6:0] S7  = 7'b1000000;
  localparam logic [6:0] S12 = 7'b0100000;
  localparam logic [6:0] S13 = 7'b0010000;
  localparam logic [6:0] S17 = 7'b0001000;
  localparam logic [6:0] S18 = 7'b0000100;
  localparam logic [6:0] S23 = 7'b0000010;
  localparam logic [6:0] S24 = 7'b0000001;
  localparam logic [31:0] RcaArg = 32'h1234_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  cmd_t exp_q[$];

  cmdseq_if bus ();

  cmdseq #(.STAT_RETRY(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.cmd_start === 1'b1) start_cnt++;

  function automatic logic [6:0] strobes();
    return {bus.cmd7st, bus.cmd12st, bus.cmd13st, bus.cmd17st,
            bus.cmd18st, bus.cmd23st, bus.cmd24st};
  endfunction

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [15:0] n);
    bus.rd_req = rd; bus.wr_req = wr; bus.blk_addr = a; bus.blk_cnt = n;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
  endtask

  // Wait (bounded) for a cmd_start, capture strobes/arg, then answer it.
  task automatic do_cmd(input logic rerr, input logic rrdy,
                        output logic [6:0] st, output logic [31:0] arg);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_start === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    st  = seen ? strobes() : 7'bx;
    arg = bus.cmd_arg;
    if (seen) begin
      @(negedge clk);
      bus.cmd_done = 1'b1; bus.resp_err = rerr; bus.resp_ready = rrdy;
      @(negedge clk);
      bus.cmd_done = 1'b0; bus.resp_err = 1'b0; bus.resp_ready = 1'b0;
    end
  endtask

  task automatic do_data(input logic derr);
    bus.data_done = 1'b1; bus.data_err = derr;
    @(negedge clk);
    bus.data_done = 1'b0; bus.data_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.done, bus.err, bus.cmd_start} !== 4'b0 || strobes() !== 7'b0
        || bus.cmd_arg !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/done/err/start=%b st=%b arg=%h, want 0",
               {bus.ready, bus.done, bus.err, bus.cmd_start}, strobes(), bus.cmd_arg);
    end
    reset = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 32'h100, 16'd1);
    @(negedge clk);
    checks++;
    if (bus.cmd_start !== 1'b0 || strobes() !== 7'b0) begin
      errors++;
      $display("FAIL req_without_init: got start=%b st=%b, want 0 0", bus.cmd_start, strobes());
    end
    bus.init_done = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: got %b want 1", bus.ready);
    end
  endtask

  task automatic test_single_read();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S7, RcaArg});
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S17, 32'h100});
    req(1'b1, 1'b0, 32'h100, 16'd1);
    checks++;
    if (bus.cmd_start !== 1'b1 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_latency: got start=%b ready=%b want 1 0", bus.cmd_start, bus.ready);
    end
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL single_read cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    do_data(1'b0);
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL single_read_done: got done/ready/err=%b want 110",
               {bus.done, bus.ready, bus.err});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b want 0", bus.done);
    end
  endtask

  task automatic test_multi_read();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S23, 32'h0000_0008});
    exp_q.push_back('{S18, 32'h2000});
    req(1'b1, 1'b0, 32'h2000, 16'd8);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL multi_read cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    do_data(1'b0);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL multi_read_done: got %b want 1", bus.done);
    end
    @(negedge clk);
  endtask

  task automatic test_write_wrap();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S13, RcaArg}); exp_q.push_back('{S24, 32'hFFFF_FFFF});
    exp_q.push_back('{S13, RcaArg}); exp_q.push_back('{S24, 32'h0});
    exp_q.push_back('{S13, RcaArg}); exp_q.push_back('{S24, 32'h1});
    req(1'b0, 1'b1, 32'hFFFF_FFFF, 16'd3);
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 2; i++) begin
        do_cmd(1'b0, 1'b1, st, arg);
        e = exp_q.pop_front();
        checks++;
        if (st !== e.st || arg !== e.arg) begin
          errors++;
          $display("FAIL write blk%0d cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                   blk, i, st, arg, e.st, e.arg);
        end
      end
      do_data(1'b0);
      checks++;
      if (bus.done !== (blk == 2)) begin
        errors++;
        $display("FAIL write_done blk%0d: got %b want %b", blk, bus.done, blk == 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stat_retry();
    logic [6:0] st; logic [31:0] arg; cmd_t e; int start0;
    start0 = start_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back('{S13, RcaArg});
    req(1'b1, 1'b0, 32'h200, 16'd1);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b0, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL retry cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL retry_err: got %b want 1", bus.err);
    end
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL retry_idle: got ready=%b done=%b want 1 0", bus.ready, bus.done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (start_cnt - start0 !== 3) begin
      errors++;
      $display("FAIL retry_starts: got %0d want 3", start_cnt - start0);
    end
  endtask

  task automatic test_cmd18_err();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S7, RcaArg});
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S23, 32'h0000_0004});
    exp_q.push_back('{S18, 32'h4000});
    exp_q.push_back('{S12, 32'h0});
    req(1'b1, 1'b0, 32'h4000, 16'd4);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_accept: got %b want 0", bus.err);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) do_data(1'b1);
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL cmd18_err cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL cmd18_err_flag: got err=%b done=%b want 1 0", bus.err, bus.done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S7, RcaArg});
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S17, 32'h55});
    req(1'b1, 1'b1, 32'h55, 16'd1);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL rd_wr_together cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    do_data(1'b0);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL rd_wr_together_done: got %b want 1", bus.done);
    end
    @(negedge clk);
  endtask

  task automatic test_init_abort();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S17, 32'h77});
    req(1'b1, 1'b0, 32'h77, 16'd1);
    do_cmd(1'b0, 1'b1, st, arg);
    e = exp_q.pop_front();
    checks++;
    if (st !== e.st || arg !== e.arg) begin
      errors++;
      $display("FAIL abort cmd0: got st=%b arg=%h want st=%b arg=%h", st, arg, e.st, e.arg);
    end
    e = exp_q.pop_front();
    checks++;
    if (strobes() !== e.st || bus.cmd_arg !== e.arg) begin
      errors++;
      $display("FAIL abort cmd1: got st=%b arg=%h want st=%b arg=%h",
               strobes(), bus.cmd_arg, e.st, e.arg);
    end
    bus.init_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || strobes() !== 7'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL init_abort: got err=%b done=%b st=%b ready=%b want 1 0 0 0",
               bus.err, bus.done, strobes(), bus.ready);
    end
    bus.init_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_dwait();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S7, RcaArg});
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S24, 32'h9});
    req(1'b0, 1'b1, 32'h9, 16'd0);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL pre_reset cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.done, bus.err, bus.cmd_start} !== 3'b0 || strobes() !== 7'b0
        || bus.cmd_arg !== 32'h0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_dwait: got done/err/start=%b st=%b arg=%h ready=%b want 0 0 0 1",
               {bus.done, bus.err, bus.cmd_start}, strobes(), bus.cmd_arg, bus.ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] st; logic [31:0] arg; cmd_t e;
    exp_q.push_back('{S7, RcaArg});
    exp_q.push_back('{S13, RcaArg});
    exp_q.push_back('{S17, 32'hABC});
    req(1'b1, 1'b0, 32'hABC, 16'd0);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 1'b1, st, arg);
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || arg !== e.arg) begin
        errors++;
        $display("FAIL post_reset cmd%0d: got st=%b arg=%h want st=%b arg=%h",
                 i, st, arg, e.st, e.arg);
      end
    end
    do_data(1'b0);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_done: got %b want 1", bus.done);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.init_done = 1'b0; bus.rca = 16'h1234;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.blk_addr = 32'h0; bus.blk_cnt = 16'h0;
    bus.cmd_done = 1'b0; bus.resp_err = 1'b0; bus.resp_ready = 1'b0;
    bus.data_done = 1'b0; bus.data_err = 1'b0;
    test_reset();
    test_single_read();
    test_multi_read();
    test_write_wrap();
    test_stat_retry();
    test_cmd18_err();
    test_simultaneous();
    test_init_abort();
    test_reset_dwait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
